exwb_arbiter: RTL and testbench

Parametrised execute-to-writeback stage between the execution units and the ROB. Each of NUM_CH execution channels (ALU, forwarder, jump, branch, mem, …) pushes tagged results into its own small FIFO. A round-robin arbiter drains up to NUM_WB results per cycle onto registered ROB write ports. Unlike a one-to-one register stage, it buffers, applies backpressure, arbitrates, and supports stall and flush.

---
 rtl/exwb_arbiter.sv | 130 +++++++++++++
 tb/tb_exwb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/exwb_arbiter.sv
// rtl/exwb_arbiter.sv - execute-to-writeback buffering and round-robin arbitration
// Per-channel result FIFOs drained onto NUM_WB registered ROB write ports.
module exwb_arbiter #(
  parameter int NUM_CH = 5,
  parameter int NUM_WB = 2,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5,
  parameter int PAY_W = 65,
  parameter logic [TAG_W-1:0] TAG_INVALID = '1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wb_stall,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*TAG_W-1:0]   in_tag,
  input  logic [NUM_CH*PAY_W-1:0]   in_payload,
  output logic [NUM_WB-1:0]         out_valid,
  output logic [NUM_WB*CH_W-1:0]    out_ch,
  output logic [NUM_WB*TAG_W-1:0]   out_tag,
  output logic [NUM_WB*PAY_W-1:0]   out_payload
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] tag_mem [NUM_CH][DEPTH];
  logic [PAY_W-1:0] pay_mem [NUM_CH][DEPTH];
  logic [PTR_W-1:0] head [NUM_CH];
  logic [PTR_W-1:0] tail [NUM_CH];
  logic [CNT_W-1:0] count [NUM_CH];
  logic [CH_W-1:0]  rr, rr_next;
  logic [NUM_CH-1:0] push, grant;
  logic [NUM_WB-1:0] port_valid;
  logic [CH_W-1:0]  port_ch [NUM_WB];
  logic             active;

  assign active = !rst && !flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // No pass-through: readiness depends only on the registered count.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = active && (count[i] < CNT_W'(DEPTH));
      push[i] = in_valid[i] && in_ready[i] && (in_tag[i*TAG_W +: TAG_W] != TAG_INVALID);
    end
  end

  always_comb begin
    int n;
    int idx_i;
    logic [CH_W-1:0] idx;
    grant = '0;
    port_valid = '0;
    for (int p = 0; p < NUM_WB; p++) port_ch[p] = '0;
    rr_next = rr;
    n = 0;
    idx_i = 0;
    idx = '0;
    if (active && !wb_stall) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx_i = int'(rr) + k;
        if (idx_i >= NUM_CH) idx_i = idx_i - NUM_CH;
        idx = CH_W'(idx_i);
        if (count[idx] != '0 && n < NUM_WB) begin
          grant[idx] = 1'b1;
          for (int p = 0; p < NUM_WB; p++) begin
            if (p == n) begin
              port_valid[p] = 1'b1;
              port_ch[p] = idx;
            end
          end
          n = n + 1;
          rr_next = (idx_i == NUM_CH - 1) ? '0 : CH_W'(idx_i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
        count[i] <= '0;
      end
      out_valid <= '0;
      out_ch <= '0;
      out_tag <= {NUM_WB{TAG_INVALID}};
      out_payload <= '0;
    end else begin
      rr <= rr_next;
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) tail[i] <= ptr_inc(tail[i]);
        if (grant[i]) head[i] <= ptr_inc(head[i]);
        if (push[i] && !grant[i]) count[i] <= count[i] + CNT_W'(1);
        else if (!push[i] && grant[i]) count[i] <= count[i] - CNT_W'(1);
      end
      for (int p = 0; p < NUM_WB; p++) begin
        if (port_valid[p]) begin
          out_valid[p] <= 1'b1;
          out_ch[p*CH_W +: CH_W] <= port_ch[p];
          out_tag[p*TAG_W +: TAG_W] <= tag_mem[port_ch[p]][head[port_ch[p]]];
          out_payload[p*PAY_W +: PAY_W] <= pay_mem[port_ch[p]][head[port_ch[p]]];
        end else begin
          out_valid[p] <= 1'b0;
          out_ch[p*CH_W +: CH_W] <= '0;
          out_tag[p*TAG_W +: TAG_W] <= TAG_INVALID;
          out_payload[p*PAY_W +: PAY_W] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        tag_mem[i][tail[i]] <= in_tag[i*TAG_W +: TAG_W];
        pay_mem[i][tail[i]] <= in_payload[i*PAY_W +: PAY_W];
      end
    end
  end

endmodule

// File: tb/tb_exwb_arbiter.sv
// tb/tb_exwb_arbiter.sv - scoreboard bench for exwb_arbiter
// Per-channel expected queues are filled on accepted handshakes and drained by the modelled arbiter.
module tb_exwb_arbiter;
  localparam int NUM_CH = 5;
  localparam int NUM_WB = 2;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;
  localparam int PAY_W = 65;
  localparam int CH_W = 3;
  localparam int ENT_W = TAG_W + PAY_W;
  localparam logic [TAG_W-1:0] TINV = '1;

  logic clk = 1'b0;
  logic rst, flush, wb_stall;
  logic [NUM_CH-1:0] in_valid, in_ready;
  logic [NUM_CH*TAG_W-1:0] in_tag;
  logic [NUM_CH*PAY_W-1:0] in_payload;
  logic [NUM_WB-1:0] out_valid;
  logic [NUM_WB*CH_W-1:0] out_ch;
  logic [NUM_WB*TAG_W-1:0] out_tag;
  logic [NUM_WB*PAY_W-1:0] out_payload;

  always #5 clk = ~clk;

  exwb_arbiter #(
    .NUM_CH(NUM_CH), .NUM_WB(NUM_WB), .DEPTH(DEPTH), .TAG_W(TAG_W), .PAY_W(PAY_W), .TAG_INVALID(TINV)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wb_stall(wb_stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_payload(in_payload),
    .out_valid(out_valid), .out_ch(out_ch), .out_tag(out_tag), .out_payload(out_payload)
  );

  logic [ENT_W-1:0] mq [NUM_CH][$];
  int m_rr;
  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [TAG_W-1:0] tag, input logic [PAY_W-1:0] pay);
    in_valid[i] = 1'b1;
    in_tag[i*TAG_W +: TAG_W] = tag;
    in_payload[i*PAY_W +: PAY_W] = pay;
  endtask

  function automatic logic [PAY_W-1:0] rnd_pay();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  task automatic step();
    logic [NUM_WB-1:0] ev;
    logic [CH_W-1:0] ech [NUM_WB];
    logic [TAG_W-1:0] etag [NUM_WB];
    logic [PAY_W-1:0] epay [NUM_WB];
    logic [NUM_CH-1:0] eready;
    logic [ENT_W-1:0] ent;
    int n, idx, new_rr;
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      eready[i] = !rst && !flush && (mq[i].size() < DEPTH);
      chk($sformatf("in_ready[%0d]", i), 128'(in_ready[i]), 128'(eready[i]));
    end
    ev = '0;
    for (int p = 0; p < NUM_WB; p++) begin
      ech[p] = '0;
      etag[p] = TINV;
      epay[p] = '0;
    end
    new_rr = m_rr;
    if (!rst && !flush && !wb_stall) begin
      n = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (m_rr + k) % NUM_CH;
        if (n < NUM_WB && mq[idx].size() > 0) begin
          ent = mq[idx].pop_front();
          ev[n] = 1'b1;
          ech[n] = CH_W'(idx);
          etag[n] = ent[ENT_W-1:PAY_W];
          epay[n] = ent[PAY_W-1:0];
          n++;
          new_rr = (idx + 1) % NUM_CH;
        end
      end
    end
    m_rr = new_rr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_valid[i] && eready[i] && in_tag[i*TAG_W +: TAG_W] != TINV)
        mq[i].push_back({in_tag[i*TAG_W +: TAG_W], in_payload[i*PAY_W +: PAY_W]});
    end
    if (rst || flush) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_rr = 0;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NUM_WB; p++) begin
      chk($sformatf("out_valid[%0d]", p), 128'(out_valid[p]), 128'(ev[p]));
      chk($sformatf("out_ch[%0d]", p), 128'(out_ch[p*CH_W +: CH_W]), 128'(ech[p]));
      chk($sformatf("out_tag[%0d]", p), 128'(out_tag[p*TAG_W +: TAG_W]), 128'(etag[p]));
      chk($sformatf("out_payload[%0d]", p), 128'(out_payload[p*PAY_W +: PAY_W]), 128'(epay[p]));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    m_rr = 0;
    rst = 1'b1;
    flush = 1'b0;
    wb_stall = 1'b0;
    in_valid = '0;
    in_tag = '0;
    in_payload = '0;
    for (int i = 0; i < NUM_CH; i++) set_ch(i, TAG_W'(i + 1), rnd_pay());
    step();
    step();
    rst = 1'b0;
    in_valid = '0;
    step();
    chk("reset_out_tag", 128'(out_tag), 128'({NUM_WB{TINV}}));

    // single result on channel 2
    set_ch(2, 5'd3, 65'h1234);
    step();
    in_valid = '0;
    step();
    chk("single_ch", 128'(out_ch[CH_W-1:0]), 128'(2));
    chk("single_payload", 128'(out_payload[PAY_W-1:0]), 128'(65'h1234));
    step();

    // contention from rr=0 with all channels pushing
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NUM_CH; i++) set_ch(i, TAG_W'((c * NUM_CH + i) % 31), rnd_pay());
      step();
    end
    in_valid = '0;
    repeat (6) step();

    // full FIFO under stall
    wb_stall = 1'b1;
    set_ch(0, 5'd1, rnd_pay());
    step();
    set_ch(0, 5'd2, rnd_pay());
    step();
    set_ch(0, 5'd3, rnd_pay());
    #1;
    chk("full_in_ready0", 128'(in_ready[0]), 128'(0));
    step();
    in_valid = '0;
    wb_stall = 1'b0;
    repeat (3) step();

    // flush with four entries buffered
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) set_ch(i, TAG_W'(10 + i), rnd_pay());
    step();
    in_valid = '0;
    wb_stall = 1'b0;
    set_ch(1, 5'd20, rnd_pay());
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = '0;
    step();
    set_ch(3, 5'd7, rnd_pay());
    set_ch(1, 5'd8, rnd_pay());
    step();
    in_valid = '0;
    step();
    step();

    // invalid tag is accepted then dropped
    set_ch(3, TINV, 65'hdead);
    step();
    in_valid = '0;
    step();
    step();

    // random traffic
    repeat (120) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 2) != 0) set_ch(i, TAG_W'($urandom_range(0, 31)), rnd_pay());
        else in_valid[i] = 1'b0;
      end
      wb_stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    in_valid = '0;
    wb_stall = 1'b0;
    flush = 1'b0;
    rst = 1'b0;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
